unibus_arbiter: RTL



---
 rtl/unibus_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/unibus_arbiter.sv
// unibus_arbiter
//   Grants the bus to one requester at a time: NPR (DMA) first, then the
//   highest BR7..BR4 line whose level is above the processor priority. BR
//   grants are only issued at an instruction boundary. A grant that is not
//   answered with SACK within TIMEOUT cycles is withdrawn, a one-cycle
//   nosack pulse is raised, and the saturating nosackcnt is incremented.
//
// Parameters
//   TIMEOUT    grant-without-SACK limit in CLOCK cycles (2..65535)
// Ports
//   CLOCK      system clock, all state changes on the rising edge
//   RESET      synchronous active-high reset
//   init_in_h  bus INIT: drop everything and return to IDLE
//   npr_in_h   NPR request
//   br_in_h    BR7..BR4 requests
//   sack_in_h  selection acknowledge
//   cpu_pri    processor priority PS<7:5>
//   insbound   CPU at an instruction boundary (BR grants allowed)
//   npg_out_h  NPR grant (registered)
//   bg_out_h   BG7..BG4 grants (registered, one-hot or zero)
//   busy       arbiter not in IDLE
//   nosack     one-cycle pulse on grant timeout
//   nosackcnt  saturating count of timeouts
//
// state | meaning
// IDLE  | no grant out; a qualifying request is granted on the next edge
// GRANT | one grant line asserted and held; waiting for SACK
// ACKED | SACK seen; grants held low until SACK is released
module unibus_arbiter #(
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        init_in_h,
  input  logic        npr_in_h,
  input  logic [7:4]  br_in_h,
  input  logic        sack_in_h,
  input  logic [2:0]  cpu_pri,
  input  logic        insbound,
  output logic        npg_out_h,
  output logic [7:4]  bg_out_h,
  output logic        busy,
  output logic        nosack,
  output logic [15:0] nosackcnt
);

  typedef enum logic [1:0] {IDLE, GRANT, ACKED} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        npg_nxt;
  logic [7:4]  bg_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        nosack_nxt;
  logic [15:0] nosackcnt_nxt;
  logic [7:4]  br_elig;
  logic [7:4]  br_pick;
  logic        req_held;

  // A BR level only competes when it is strictly above the processor priority.
  always_comb begin
    br_elig[7] = br_in_h[7] && (cpu_pri < 3'd7);
    br_elig[6] = br_in_h[6] && (cpu_pri < 3'd6);
    br_elig[5] = br_in_h[5] && (cpu_pri < 3'd5);
    br_elig[4] = br_in_h[4] && (cpu_pri < 3'd4);
  end

  always_comb begin
    br_pick = 4'b0000;
    casez (br_elig)
      4'b1???: br_pick = 4'b1000;
      4'b01??: br_pick = 4'b0100;
      4'b001?: br_pick = 4'b0010;
      4'b0001: br_pick = 4'b0001;
      default: br_pick = 4'b0000;
    endcase
  end

  // The registered grant itself identifies which request was latched.
  assign req_held = npg_out_h ? npr_in_h : |(bg_out_h & br_in_h);

  always_comb begin
    state_nxt     = state;
    npg_nxt       = npg_out_h;
    bg_nxt        = bg_out_h;
    cnt_nxt       = cnt;
    nosack_nxt    = 1'b0;
    nosackcnt_nxt = nosackcnt;
    if (init_in_h) begin
      state_nxt = IDLE;
      npg_nxt   = 1'b0;
      bg_nxt    = 4'b0000;
      cnt_nxt   = 16'd0;
    end else begin
      case (state)
        IDLE: begin
          npg_nxt = 1'b0;
          bg_nxt  = 4'b0000;
          cnt_nxt = 16'd0;
          if (!sack_in_h) begin
            if (npr_in_h) begin
              npg_nxt   = 1'b1;
              state_nxt = GRANT;
            end else if (insbound && (br_pick != 4'b0000)) begin
              bg_nxt    = br_pick;
              state_nxt = GRANT;
            end
          end
        end
        GRANT: begin
          // SACK outranks both passive release and an expiring timer.
          if (sack_in_h) begin
            state_nxt = ACKED;
            npg_nxt   = 1'b0;
            bg_nxt    = 4'b0000;
            cnt_nxt   = 16'd0;
          end else if (!req_held) begin
            state_nxt = IDLE;
            npg_nxt   = 1'b0;
            bg_nxt    = 4'b0000;
            cnt_nxt   = 16'd0;
          end else if (cnt == CNT_LAST) begin
            state_nxt  = IDLE;
            npg_nxt    = 1'b0;
            bg_nxt     = 4'b0000;
            cnt_nxt    = 16'd0;
            nosack_nxt = 1'b1;
            if (nosackcnt != 16'hFFFF) nosackcnt_nxt = nosackcnt + 16'd1;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        ACKED: begin
          npg_nxt = 1'b0;
          bg_nxt  = 4'b0000;
          cnt_nxt = 16'd0;
          if (!sack_in_h) state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
          npg_nxt   = 1'b0;
          bg_nxt    = 4'b0000;
          cnt_nxt   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state     <= IDLE;
      npg_out_h <= 1'b0;
      bg_out_h  <= 4'b0000;
      cnt       <= 16'd0;
      nosack    <= 1'b0;
      nosackcnt <= 16'd0;
    end else begin
      state     <= state_nxt;
      npg_out_h <= npg_nxt;
      bg_out_h  <= bg_nxt;
      cnt       <= cnt_nxt;
      nosack    <= nosack_nxt;
      nosackcnt <= nosackcnt_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
